// File: rtl/sweep_sequencer_pkg.sv
// Shared types and widths for the antenna sweep sequencer.
package sweep_sequencer_pkg;
   localparam int ANGLE_W = 8;
   localparam int ADC_W   = 12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MOVE,
      ST_SAMPLE,
      ST_COMPARE,
      ST_NEXT,
      ST_PARK
   } state_t;

   typedef enum logic {
      AX_THETA,
      AX_PHI
   } axis_t;
endpackage

// File: rtl/sweep_sequencer_sweep_timer.sv
// Down-counter shared by the servo settle wait and the ADC timeout.
module sweep_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         expired
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   // Flags the last enabled cycle of a loaded count (load value N -> N enabled cycles).
   assign expired = en && (cnt <= W'(1));
endmodule

// File: rtl/sweep_sequencer.sv
// Two-pass peak search: full theta sweep at phi=0, then phi sweep at the best theta.
module sweep_sequencer
   import sweep_sequencer_pkg::*;
#(
   parameter int THETA_MAX     = 179,
   parameter int PHI_MAX       = 90,
   parameter int SETTLE_CYCLES = 50000,
   parameter int ADC_TIMEOUT   = 1024
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
   input  logic [ADC_W-1:0]   adc_data,
   input  logic               adc_valid,
   output logic               adc_req,
   output logic [ANGLE_W-1:0] theta,
   output logic [ANGLE_W-1:0] phi,
   output logic [ADC_W-1:0]   best_v,
   output logic [ANGLE_W-1:0] best_theta,
   output logic [ANGLE_W-1:0] best_phi,
   output logic               busy,
   output logic               done,
   output logic               adc_err
);
   localparam int TMAX = (SETTLE_CYCLES > ADC_TIMEOUT) ? SETTLE_CYCLES : ADC_TIMEOUT;
   localparam int TW   = $clog2(TMAX + 1);

   state_t           state;
   axis_t            axis;
   logic [ADC_W-1:0] sample;
   logic             tmr_load;
   logic             tmr_en;
   logic [TW-1:0]    tmr_val;
   logic             tmr_expired;

   // Timer is reloaded in every non-counting state, so MOVE always starts from SETTLE_CYCLES.
   always_comb begin
      tmr_en   = (state == ST_MOVE) || (state == ST_SAMPLE);
      tmr_load = !tmr_en || ((state == ST_MOVE) && tmr_expired);
      tmr_val  = (state == ST_MOVE) ? TW'(ADC_TIMEOUT) : TW'(SETTLE_CYCLES);
   end

   sweep_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .expired  (tmr_expired)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         axis       <= AX_THETA;
         sample     <= '0;
         adc_req    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         adc_err    <= 1'b0;
         theta      <= '0;
         phi        <= '0;
         best_v     <= '0;
         best_theta <= '0;
         best_phi   <= '0;
      end else begin
         done <= 1'b0;
         if (abort && (state != ST_IDLE)) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            adc_req <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start && !abort) begin
                     theta      <= '0;
                     phi        <= '0;
                     best_v     <= '0;
                     best_theta <= '0;
                     best_phi   <= '0;
                     adc_err    <= 1'b0;
                     axis       <= AX_THETA;
                     busy       <= 1'b1;
                     state      <= ST_MOVE;
                  end
               end
               ST_MOVE: begin
                  if (tmr_expired) begin
                     adc_req <= 1'b1;
                     state   <= ST_SAMPLE;
                  end
               end
               ST_SAMPLE: begin
                  if (adc_valid) begin
                     sample  <= adc_data;
                     adc_req <= 1'b0;
                     state   <= ST_COMPARE;
                  end else if (tmr_expired) begin
                     sample  <= '0;
                     adc_err <= 1'b1;
                     adc_req <= 1'b0;
                     state   <= ST_COMPARE;
                  end
               end
               ST_COMPARE: begin
                  if (sample > best_v) begin
                     best_v     <= sample;
                     best_theta <= theta;
                     best_phi   <= phi;
                  end
                  state <= ST_NEXT;
               end
               ST_NEXT: begin
                  if (axis == AX_THETA) begin
                     if (theta < ANGLE_W'(THETA_MAX)) begin
                        theta <= theta + 1'b1;
                     end else begin
                        theta <= best_theta;
                        phi   <= '0;
                        axis  <= AX_PHI;
                     end
                     state <= ST_MOVE;
                  end else if (phi < ANGLE_W'(PHI_MAX)) begin
                     phi   <= phi + 1'b1;
                     state <= ST_MOVE;
                  end else begin
                     state <= ST_PARK;
                  end
               end
               ST_PARK: begin
                  theta <= best_theta;
                  phi   <= best_phi;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_sweep_sequencer.sv
// Scoreboarded bench: directed sweeps with a scripted ADC responder.
module tb_sweep_sequencer;
   import sweep_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [11:0] adc_data = 12'hFFE;
   logic        adc_valid = 1'b0;
   logic        adc_req, busy, done, adc_err;
   logic [7:0]  theta, phi, best_theta, best_phi;
   logic [11:0] best_v;

   always #5 clk = ~clk;

   sweep_sequencer #(
      .THETA_MAX     (3),
      .PHI_MAX       (2),
      .SETTLE_CYCLES (2),
      .ADC_TIMEOUT   (8)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .abort      (abort),
      .adc_data   (adc_data),
      .adc_valid  (adc_valid),
      .adc_req    (adc_req),
      .theta      (theta),
      .phi        (phi),
      .best_v     (best_v),
      .best_theta (best_theta),
      .best_phi   (best_phi),
      .busy       (busy),
      .done       (done),
      .adc_err    (adc_err)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic [11:0] bv;
      logic [7:0]  bt;
      logic [7:0]  bp;
      logic [7:0]  t;
      logic [7:0]  p;
      logic        err;
   } res_t;

   res_t res_q[$];
   int   len_q[$];

   // ADC responder: answers on the 4th cycle of adc_req (3 cycles after it rises).
   logic [11:0] vals[7];
   logic        resp_en[7];
   logic        spurious = 1'b0;
   int          idx = 0;
   int          req_cnt = 0;
   logic        rsp_prev_req = 1'b0;

   always @(negedge clk) begin
      if (!busy) idx = 0;
      else if (rsp_prev_req && !adc_req) idx = idx + 1;
      rsp_prev_req = adc_req;
      if (adc_req) req_cnt = req_cnt + 1;
      else req_cnt = 0;
      if (adc_req && req_cnt == 4 && idx < 7 && resp_en[idx]) begin
         adc_valid = 1'b1;
         adc_data  = vals[idx];
      end else if (!adc_req && spurious) begin
         adc_valid = 1'b1;
         adc_data  = 12'hFFE;
      end else begin
         adc_valid = 1'b0;
         adc_data  = 12'hFFE;
      end
   end

   // Monitor: request lengths, settle gaps and sweep results.
   int   mon_len = 0;
   int   gap = 0;
   bit   had_fall = 1'b0;
   logic mon_prev_req = 1'b0;
   logic prev_done = 1'b0;
   int   done_cnt = 0;
   res_t r;

   always @(negedge clk) begin
      if (adc_req) begin
         if (!mon_prev_req && had_fall) check("move_gap", gap, 4);
         mon_len++;
      end else begin
         if (mon_prev_req) begin
            if (len_q.size() > 0) check("req_len", mon_len, len_q.pop_front());
            else check("req_len_unexpected", mon_len, 0);
            had_fall = 1'b1;
            gap      = 0;
            mon_len  = 0;
         end
         gap++;
      end
      if (!busy && !adc_req) had_fall = 1'b0;
      if (done) begin
         done_cnt++;
         check("done_single", prev_done, 0);
         if (res_q.size() > 0) begin
            r = res_q.pop_front();
            check("best_v", best_v, r.bv);
            check("best_theta", best_theta, r.bt);
            check("best_phi", best_phi, r.bp);
            check("park_theta", theta, r.t);
            check("park_phi", phi, r.p);
            check("adc_err", adc_err, r.err);
            check("busy_at_done", busy, 0);
         end else begin
            check("unexpected_done", done, 0);
         end
      end
      prev_done    = done;
      mon_prev_req = adc_req;
   end

   task automatic set_vals(input logic [11:0] a0, a1, a2, a3, a4, a5, a6);
      vals[0] = a0; vals[1] = a1; vals[2] = a2; vals[3] = a3;
      vals[4] = a4; vals[5] = a5; vals[6] = a6;
      for (int i = 0; i < 7; i++) resp_en[i] = 1'b1;
   endtask

   task automatic push_lens(input int n, input int len);
      for (int i = 0; i < n; i++) len_q.push_back(len);
   endtask

   task automatic push_res(input logic [11:0] bv, input logic [7:0] bt, bp, t, p,
                           input logic err);
      res_t x;
      x.bv = bv; x.bt = bt; x.bp = bp; x.t = t; x.p = p; x.err = err;
      res_q.push_back(x);
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      for (int c = 0; c < budget && done_cnt < target; c++) @(posedge clk);
      check("done_reached", done_cnt >= target, 1);
   endtask

   int d0;
   bit hit;

   initial begin
      set_vals(12'd100, 12'd400, 12'd400, 12'd50, 12'd400, 12'd900, 12'd10);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_adc_req", adc_req, 0);
      check("rst_adc_err", adc_err, 0);
      check("rst_theta", theta, 0);
      check("rst_phi", phi, 0);
      check("rst_best_v", best_v, 0);
      check("rst_best_theta", best_theta, 0);
      check("rst_best_phi", best_phi, 0);
      reset_n = 1'b1;
      @(negedge clk);
      check("idle_busy", busy, 0);

      // Reset in the MOVE of the second theta step
      push_lens(1, 4);
      pulse_start();
      check("start_busy", busy, 1);
      hit = 1'b0;
      for (int c = 0; c < 100 && !hit; c++) begin
         @(posedge clk);
         hit = (idx == 1);
      end
      check("reach_step1", hit, 1);
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_theta", theta, 1);
      check("pre_rst_best_v", best_v, 100);
      reset_n = 1'b0;
      #1;
      check("async_busy", busy, 0);
      check("async_theta", theta, 0);
      check("async_best_v", best_v, 0);
      check("async_best_theta", best_theta, 0);
      @(negedge clk) reset_n = 1'b1;
      repeat (5) @(negedge clk);
      check("no_restart_busy", busy, 0);

      // Nominal sweep, with a start pulse mid-sweep that must be ignored
      push_res(12'd900, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
      push_lens(7, 4);
      d0 = done_cnt;
      pulse_start();
      repeat (20) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_done(d0 + 1, 400);
      repeat (10) @(posedge clk);
      check("sweep_count", done_cnt - d0, 1);

      // Missing response at theta=2, spurious valids outside SAMPLE
      set_vals(12'd100, 12'd400, 12'd0, 12'd50, 12'd300, 12'd200, 12'd500);
      resp_en[2] = 1'b0;
      spurious   = 1'b1;
      push_res(12'd500, 8'd1, 8'd2, 8'd1, 8'd2, 1'b1);
      len_q.push_back(4); len_q.push_back(4); len_q.push_back(8);
      push_lens(4, 4);
      d0 = done_cnt;
      pulse_start();
      wait_done(d0 + 1, 400);
      @(negedge clk);
      check("err_sticky", adc_err, 1);
      spurious = 1'b0;

      // Abort during the phi=1 sample
      set_vals(12'd100, 12'd400, 12'd400, 12'd50, 12'd400, 12'd900, 12'd10);
      push_lens(5, 4);
      len_q.push_back(3);
      d0 = done_cnt;
      pulse_start();
      hit = 1'b0;
      for (int c = 0; c < 400 && !hit; c++) begin
         @(posedge clk);
         hit = (idx == 5) && (req_cnt == 2);
      end
      check("reach_phi1", hit, 1);
      @(negedge clk) abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_adc_req", adc_req, 0);
      check("abort_best_v", best_v, 400);
      check("abort_best_theta", best_theta, 1);
      check("abort_best_phi", best_phi, 0);
      check("abort_theta", theta, 1);
      check("abort_phi", phi, 1);
      repeat (20) @(posedge clk);
      check("abort_no_done", done_cnt - d0, 0);

      // Restart with every sample at full scale: ties keep theta=0, phi=0
      set_vals(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
      push_res(12'hFFF, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
      push_lens(7, 4);
      d0 = done_cnt;
      pulse_start();
      check("restart_best_v", best_v, 0);
      check("restart_theta", theta, 0);
      check("restart_phi", phi, 0);
      wait_done(d0 + 1, 400);
      repeat (5) @(posedge clk);

      check("res_q_empty", res_q.size(), 0);
      check("len_q_empty", len_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
